// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU share arbiter.
package alu_arb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd15;

  typedef struct packed {
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [3:0]      sel;
  } alu_req_t;

  localparam alu_req_t OP_IDLE = '{src1: '0, src2: '0, sel: ALU_PASS};

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search starting at ptr, wrapping upward.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // walk from farthest to nearest so the closest candidate to ptr wins last
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (req[k]) begin
        idx = IDX_W'(k);
        any = 1'b1;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU between NUM_REQ requesters.
// Optional macro ALU_ARB_BACK2BACK_EN: arbitrate again in RESP on the response handshake.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*XLEN-1:0] req_src1_i,
  input  logic [NUM_REQ*XLEN-1:0] req_src2_i,
  input  logic [NUM_REQ*4-1:0]    req_sel_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  input  logic [NUM_REQ-1:0]      rsp_ready_i,
  output logic [XLEN-1:0]         rsp_result_o,
  output logic                    rsp_zero_o,
  output logic [XLEN-1:0]         alu_src1_o,
  output logic [XLEN-1:0]         alu_src2_o,
  output logic [3:0]              alu_sel_o,
  input  logic [XLEN-1:0]         alu_result_i,
  input  logic                    alu_zero_i
);

  // width kept at least 1 so NUM_REQ=1 still elaborates
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q, gidx_q, arb_idx, ptr_nxt;
  logic [NUM_REQ-1:0] arb_gnt;
  logic              arb_any, arb_en, take;
  alu_req_t          op_q, req_op;
  logic [XLEN-1:0]   res_q;
  logic              zero_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req (req_valid_i),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    arb_en = (state_q == IDLE);
`ifdef ALU_ARB_BACK2BACK_EN
    if (state_q == RESP && rsp_ready_i[gidx_q]) arb_en = 1'b1;
`endif
  end

  assign req_ready_o = arb_en ? arb_gnt : '0;
  assign take        = arb_en & arb_any;
  assign ptr_nxt     = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IDX_W'(1);

  assign req_op = '{src1: req_src1_i[int'(arb_idx)*XLEN +: XLEN],
                    src2: req_src2_i[int'(arb_idx)*XLEN +: XLEN],
                    sel:  req_sel_i[int'(arb_idx)*4 +: 4]};

  // op_q is cleared back to OP_IDLE after ISSUE, so it feeds the ALU directly
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      op_q    <= OP_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      if (take) begin
        op_q   <= req_op;
        gidx_q <= arb_idx;
        ptr_q  <= ptr_nxt;
      end
      case (state_q)
        IDLE:  if (take) state_q <= ISSUE;
        ISSUE: begin
          res_q   <= alu_result_i;
          zero_q  <= alu_zero_i;
          op_q    <= OP_IDLE;
          state_q <= RESP;
        end
        RESP:  if (rsp_ready_i[gidx_q]) state_q <= take ? ISSUE : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_rsp
    assign rsp_valid_o[k] = (state_q == RESP) && (int'(gidx_q) == k);
  end

  assign rsp_result_o = res_q;
  assign rsp_zero_o   = zero_q;
  assign alu_src1_o   = op_q.src1;
  assign alu_src2_o   = op_q.src2;
  assign alu_sel_o    = op_q.sel;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized + directed bench for alu_share_arbiter against a transaction-level model.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*32-1:0] src1, src2;
  logic [N*4-1:0]  sel;
  logic [31:0]   rsp_result, alu_src1, alu_src2, alu_result;
  logic          rsp_zero, alu_zero;
  logic [3:0]    alu_sel;

  int checks = 0;
  int failures = 0;

  // model: one outstanding op, its age in cycles since acceptance, last granted index
  bit          m_busy;
  int          m_g, m_age, m_last;
  logic [31:0] m_s1, m_s2, m_res;
  logic [3:0]  m_sel;

  logic [N-1:0] o_ready, o_rsp;
  logic [31:0]  o_res;
  logic         o_zero;
  logic [3:0]   o_sel;

  alu_share_arbiter #(.NUM_REQ(N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_src1_i(src1), .req_src2_i(src2), .req_sel_i(sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero),
    .alu_src1_o(alu_src1), .alu_src2_o(alu_src2), .alu_sel_o(alu_sel),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero)
  );

  function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] s);
    case (s)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_f(alu_src1, alu_src2, alu_sel);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_req(int k, bit v, logic [3:0] s, logic [31:0] a, logic [31:0] b);
    req_valid[k]   = v;
    sel[k*4 +: 4]  = s;
    src1[k*32 +: 32] = a;
    src2[k*32 +: 32] = b;
  endtask

  task automatic cyc();
    logic [N-1:0] er, ev;
    bit allow;
    int w, j;
    @(negedge clk);
    ev = (m_busy && m_age >= 2) ? N'(1 << m_g) : '0;
    allow = !m_busy;
`ifdef ALU_ARB_BACK2BACK_EN
    if (m_busy && m_age >= 2 && rsp_ready[m_g]) allow = 1'b1;
`endif
    w = -1;
    for (int i = N - 1; i >= 0; i--) begin
      j = (m_last + 1 + i) % N;
      if (req_valid[j]) w = j;
    end
    er = (allow && w >= 0) ? N'(1 << w) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (m_busy && m_age == 1) begin
      chk("alu_src1", alu_src1, m_s1);
      chk("alu_src2", alu_src2, m_s2);
      chk("alu_sel", 32'(alu_sel), 32'(m_sel));
    end else begin
      chk("alu_src1_idle", alu_src1, 32'd0);
      chk("alu_src2_idle", alu_src2, 32'd0);
      chk("alu_sel_idle", 32'(alu_sel), 32'hF);
    end
    if (ev != '0) begin
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_zero", 32'(rsp_zero), 32'(m_res == 32'd0));
    end
    o_ready = req_ready; o_rsp = rsp_valid; o_res = rsp_result;
    o_zero = rsp_zero; o_sel = alu_sel;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = N - 1;
    end else begin
      if (m_busy) m_age++;
      if (ev != '0 && rsp_ready[m_g]) m_busy = 1'b0;
      if (er != '0) begin
        m_busy = 1'b1; m_age = 1; m_g = w; m_last = w;
        m_s1 = src1[w*32 +: 32]; m_s2 = src2[w*32 +: 32]; m_sel = sel[w*4 +: 4];
        m_res = alu_f(m_s1, m_s2, m_sel);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) cyc();
  endtask

  initial begin
    logic [N-1:0] prev;
    int seen, last_rsp, n;
    rst_n = 1'b0; req_valid = '0; src1 = '0; src2 = '0; sel = '0; rsp_ready = '1;
    m_busy = 1'b0; m_last = N - 1; m_g = 0; m_age = 0;
    m_s1 = '0; m_s2 = '0; m_sel = ALU_PASS; m_res = '0;
    @(posedge clk); #1;
    cyc();
    chk("rst_result", o_res, 32'd0);
    chk("rst_zero", 32'(o_zero), 32'd0);
    chk("rst_sel", 32'(o_sel), 32'hF);
    chk("rst_rsp", 32'(o_rsp), 32'd0);
    rst_n = 1'b1;
    cyc();

    // single ADD from req0
    set_req(0, 1, ALU_ADD, 32'd5, 32'd7);
    cyc(); chk("s1_ready", 32'(o_ready), 32'd1);
    req_valid[0] = 1'b0;
    cyc(); chk("s1_sel", 32'(o_sel), 32'(ALU_ADD));
    cyc(); chk("s1_rsp", 32'(o_rsp), 32'd1);
    chk("s1_res", o_res, 32'd12);
    chk("s1_zero", 32'(o_zero), 32'd0);
    cyc();

    // SUB 9-9 from req1 with response backpressure
    set_req(1, 1, ALU_SUB, 32'd9, 32'd9);
    cyc(); chk("s2_ready", 32'(o_ready), 32'd2);
    req_valid[1] = 1'b0; rsp_ready = '0;
    set_req(0, 1, ALU_ADD, 32'd1, 32'd2);
    cyc();
    repeat (4) begin
      cyc();
      chk("s2_hold_rsp", 32'(o_rsp), 32'd2);
      chk("s2_hold_res", o_res, 32'd0);
      chk("s2_hold_zero", 32'(o_zero), 32'd1);
      chk("s2_hold_ready", 32'(o_ready), 32'd0);
    end
    rsp_ready = '1;
    cyc();
    drain();

    // both requesters valid: grants must alternate
    set_req(0, 1, ALU_XOR, 32'hA5A5, 32'h0F0F);
    set_req(1, 1, ALU_SLL, 32'd1, 32'd4);
    prev = '0;
    repeat (16) begin
      cyc();
      if (o_ready != '0) begin
        if (prev != '0) chk("s3_alt", 32'(o_ready != prev), 32'd1);
        prev = o_ready;
      end
      if (o_rsp == N'(2)) chk("s3_sll", o_res, 32'h10);
    end
    drain();

    // wrap-around: move pointer to 3, then valid=1001
    set_req(2, 1, ALU_OR, 32'd3, 32'd4);
    cyc(); chk("s4_g2", 32'(o_ready), 32'd4);
    req_valid = '0;
    cyc(); cyc();
    set_req(0, 1, ALU_AND, 32'hFF, 32'h0F);
    set_req(3, 1, ALU_ADD, 32'd100, 32'd1);
    cyc(); chk("s4_g3", 32'(o_ready), 32'd8);
    seen = 0;
    repeat (4) begin
      cyc();
      if (o_ready != '0 && seen == 0) begin
        chk("s4_wrap", 32'(o_ready), 32'd1);
        seen = 1;
      end
    end
    chk("s4_seen", 32'(seen), 32'd1);
    drain();

    // reset during ISSUE drops the op and clears the pointer
    set_req(1, 1, ALU_ADD, 32'd1, 32'd1);
    cyc(); chk("s5_ready", 32'(o_ready), 32'd2);
    req_valid = '0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("s5_rsp", 32'(o_rsp), 32'd0);
    chk("s5_sel", 32'(o_sel), 32'hF);
    chk("s5_res", o_res, 32'd0);
    chk("s5_zero", 32'(o_zero), 32'd0);
    set_req(1, 1, ALU_ADD, 32'd2, 32'd3);
    set_req(2, 1, ALU_ADD, 32'd4, 32'd5);
    cyc(); chk("s5_first", 32'(o_ready), 32'd2);
    drain();

`ifdef ALU_ARB_BACK2BACK_EN
    set_req(0, 1, ALU_SRA, 32'h8000_0000, 32'd4);
    set_req(1, 1, ALU_ADD, 32'd3, 32'd4);
    last_rsp = -1;
    for (n = 0; n < 14; n++) begin
      cyc();
      if (o_rsp != '0) begin
        if (last_rsp >= 0) chk("b2b_gap", 32'(n - last_rsp), 32'd2);
        last_rsp = n;
      end
      if (o_rsp == N'(1)) chk("b2b_sra", o_res, 32'hF800_0000);
    end
    drain();
`endif

    // random traffic
    repeat (600) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0)
          set_req(k, $urandom_range(0, 1), 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        else
          set_req(k, $urandom_range(0, 1), 4'($urandom), $urandom, $urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0) ? '1 : N'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      cyc();
    end
    rst_n = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
